// File: rtl/pc_fetch_unit.sv
// PC owner and instruction fetch front end: one outstanding imem request feeding a small
// prefetch FIFO toward decode. Optional macro FETCH_PERF_CNT_EN adds fetch_bubble_cnt.
module pc_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                FIFO_DEP = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  output logic [1:0]         dbg_state
`ifdef FETCH_PERF_CNT_EN
  ,output logic [15:0]       fetch_bubble_cnt
`endif
);

  localparam int PTR_W = (FIFO_DEP > 1) ? $clog2(FIFO_DEP) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEP_C = CNT_W'(FIFO_DEP);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]         state, state_nxt;
  logic               kill, kill_nxt;
  logic [ADDR_W-1:0]  req_addr;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count, count_nxt;
  logic [INSTR_W-1:0] fifo_instr [FIFO_DEP];
  logic [ADDR_W-1:0]  fifo_pc    [FIFO_DEP];
  logic               push, pop, gnt_fire, has_room;

  // Handshakes: imem transfers on imem_req && imem_gnt; decode pops on instr_valid && instr_ready.
  // imem_req/imem_addr stay stable until granted unless a redirect lands.
  assign imem_req    = (state == S_REQ);
  assign imem_addr   = pc;
  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? fifo_instr[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]    : '0;
  assign dbg_state   = state;

  assign gnt_fire = imem_req && imem_gnt;
  // A killed (stale) response or one landing with a redirect is never pushed.
  assign push     = (state == S_WAIT) && imem_rvalid && !kill && !redirect_valid;
  assign pop      = instr_valid && instr_ready && !redirect_valid;

  always_comb begin
    count_nxt = count;
    if (push && !pop) count_nxt = count + 1'b1;
    else if (pop && !push) count_nxt = count - 1'b1;
  end

  assign has_room = (count_nxt < DEP_C);

  always_comb begin
    state_nxt = state;
    kill_nxt  = kill;
    case (state)
      S_IDLE: begin
        if (redirect_valid || (count < DEP_C)) state_nxt = S_REQ;
      end
      S_REQ: begin
        if (imem_gnt) begin
          state_nxt = S_WAIT;
          kill_nxt  = redirect_valid;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          kill_nxt  = 1'b0;
          state_nxt = (redirect_valid || has_room) ? S_REQ : S_IDLE;
        end else if (redirect_valid) begin
          kill_nxt = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      kill     <= 1'b0;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state <= state_nxt;
      kill  <= kill_nxt;
      if (gnt_fire) req_addr <= pc;
      if (redirect_valid) pc <= redirect_pc;
      else if (gnt_fire) pc <= pc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
    end
  end

  // Storage needs no reset: outputs are gated by instr_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]    <= req_addr;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_bubble_cnt <= '0;
    end else if (!instr_valid && instr_ready && (fetch_bubble_cnt != 16'hFFFF)) begin
      fetch_bubble_cnt <= fetch_bubble_cnt + 16'd1;
    end
  end
`endif

endmodule
